// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
// Shared types and defaults for the program-RAM port arbiter.
//   arb_state_t      : arbiter FSM states
//   DEF_ADDR_W       : default word-address width of program RAM
//   DEF_DATA_W       : default RAM word width (multiple of 8)
//   DEF_STARVE_MAX   : default CPU grants tolerated while the host waits
//   BYTES_PER_WORD   : bytes streamed per default-width word
//   bytes_per_word() : bytes per word for an arbitrary word width
package ram_port_arbiter_pkg;

  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;
  localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    CPU_RSP,
    HOST_ACC,
    HOST_CAP
  } arb_state_t;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
// Bundles the CPU access port, host readout port, byte stream and the
// single-port RAM connection used by ram_port_arbiter.
//   slave  modport : arbiter side (consumes requests, drives acks/stream/RAM)
//   master modport : environment side (CPU, host, byte sink and the RAM)
// Parameters ADDR_W / DATA_W must match those of the arbiter instance.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();

  // CPU access port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  // Host word-read request
  logic              host_req;
  logic [ADDR_W-1:0] host_addr;

  // Byte stream toward the host
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic              byte_last;

  // Single-port synchronous RAM
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  host_req, host_addr,
    output byte_out, byte_valid, byte_last,
    input  byte_ready,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output host_req, host_addr,
    input  byte_out, byte_valid, byte_last,
    output byte_ready,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/ram_byte_serializer.sv
// ram_byte_serializer
// Holds one captured RAM word and streams it LSB byte first over a
// valid/ready byte port.
//   clk, rst   : clock, synchronous active-high reset (flushes the word)
//   load       : capture load_word and start streaming next cycle
//   load_word  : word to stream
//   byte_out   : current byte, stable while valid and not ready
//   byte_valid : byte_out is valid
//   byte_ready : sink accepts the byte when valid & ready
//   byte_last  : current byte is the final one of the word
//   busy       : a word is still being streamed
module ram_byte_serializer
  import ram_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_word,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              byte_last,
  output logic              busy
);

  localparam int BYTES = bytes_per_word(DATA_W);
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  logic [DATA_W-1:0] shift_reg;
  logic [IW-1:0]     idx;
  logic              valid;

  // The word is shifted right on every accepted byte, so the low byte is
  // always the one on offer and the register drains to zero by the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      idx       <= '0;
      valid     <= 1'b0;
    end else if (load) begin
      shift_reg <= load_word;
      idx       <= '0;
      valid     <= 1'b1;
    end else if (valid && byte_ready) begin
      shift_reg <= shift_reg >> 8;
      if (idx == LAST_IDX) begin
        idx   <= '0;
        valid <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign byte_out   = shift_reg[7:0];
  assign byte_valid = valid;
  assign byte_last  = valid && (idx == LAST_IDX);
  assign busy       = valid;

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares the single-port program RAM between the CPU and the host readout
// path. One 32-bit access per grant; CPU has priority, but after STARVE_MAX
// CPU grants while the host waits, the host is forced to win. Host words are
// streamed out by ram_byte_serializer, LSB byte first.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ram_port_arbiter_if.slave carrying the CPU port, host request,
//              byte stream and RAM connection
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic             clk,
  input  logic             rst,
  ram_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

  arb_state_t        state;
  logic [CW-1:0]     starve_cnt;
  logic              we_q;
  logic [DATA_W-1:0] rdata_hold;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              cpu_ack;

  logic              ser_load;
  logic              ser_busy;
  logic              host_ok;
  logic [7:0]        ser_byte;
  logic              ser_valid;
  logic              ser_last;

  // A host request only counts while no word is still being streamed.
  assign host_ok  = bus.host_req && !ser_busy;
  assign ser_load = (state == HOST_CAP);

  // Arbiter FSM. The ram_* strobes are registered at grant time so they are
  // high exactly during the *_ACC state and return to zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      we_q       <= 1'b0;
      rdata_hold <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_ack    <= 1'b0;
    end else begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (host_ok && ((starve_cnt == STARVE_TOP) || !bus.cpu_req)) begin
            ram_en     <= 1'b1;
            ram_addr   <= bus.host_addr;
            starve_cnt <= '0;
            state      <= HOST_ACC;
          end else if (bus.cpu_req) begin
            ram_en    <= 1'b1;
            ram_we    <= bus.cpu_we;
            ram_addr  <= bus.cpu_addr;
            ram_wdata <= bus.cpu_wdata;
            we_q      <= bus.cpu_we;
            if (host_ok && (starve_cnt != STARVE_TOP)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
            state <= CPU_ACC;
          end
        end
        CPU_ACC: begin
          cpu_ack <= 1'b1;
          state   <= CPU_RSP;
        end
        CPU_RSP: begin
          if (!we_q) begin
            rdata_hold <= bus.ram_rdata;
          end
          state <= IDLE;
        end
        HOST_ACC: state <= HOST_CAP;
        HOST_CAP: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  ram_byte_serializer #(
    .DATA_W(DATA_W)
  ) u_serializer (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .load_word  (bus.ram_rdata),
    .byte_out   (ser_byte),
    .byte_valid (ser_valid),
    .byte_ready (bus.byte_ready),
    .byte_last  (ser_last),
    .busy       (ser_busy)
  );

  // Read data is forwarded straight from the RAM during the ack cycle so it
  // is visible together with cpu_ack; the held copy covers later cycles.
  assign bus.cpu_rdata  = ((state == CPU_RSP) && !we_q) ? bus.ram_rdata : rdata_hold;
  assign bus.cpu_ack    = cpu_ack;
  assign bus.ram_en     = ram_en;
  assign bus.ram_we     = ram_we;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_wdata  = ram_wdata;
  assign bus.byte_out   = ser_byte;
  assign bus.byte_valid = ser_valid;
  assign bus.byte_last  = ser_last;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Self-checking bench for ram_port_arbiter. A sync RAM model answers the
// DUT's RAM port. A transaction-level reference model schedules the expected
// outputs of every grant and checks every cycle; directed scenarios add
// literal expectations, followed by a randomized phase.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int WORDS      = 2 ** ADDR_W;
  localparam int MAXC       = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM seen by the DUT
  logic [DATA_W-1:0] ram_mem [WORDS];
  logic [DATA_W-1:0] ram_q = '0;
  assign bus.ram_rdata = ram_q;

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      else            ram_q <= ram_mem[bus.ram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: per-cycle expectation tables filled in when a grant
  // is decided, plus the model's own view of RAM contents and byte stream.
  bit                armed = 1'b0;
  int                idle_at = 0;
  int                starve_m = 0;
  logic [DATA_W-1:0] hold_m = '0;
  logic [DATA_W-1:0] mem_m [WORDS];
  logic [7:0]        q_m [$];
  int                sstart = 0;
  bit                exp_en   [MAXC];
  bit                exp_we   [MAXC];
  bit [ADDR_W-1:0]   exp_addr [MAXC];
  bit [DATA_W-1:0]   exp_wd   [MAXC];
  bit                exp_ack  [MAXC];
  bit                exp_rdv  [MAXC];
  bit [DATA_W-1:0]   exp_rdd  [MAXC];

  always @(negedge clk) begin : model_proc
    int c;
    bit sv;
    bit sl;
    logic [7:0] sb;
    bit host_ok;
    logic [DATA_W-1:0] w;
    c  = cyc;
    sv = 1'b0;
    if (c + 4 < MAXC) begin
      if (armed) begin
        if (exp_rdv[c]) hold_m = exp_rdd[c];
        sv = (q_m.size() > 0) && (c >= sstart);
        sb = sv ? q_m[0] : 8'h00;
        sl = sv && (q_m.size() == 1);
        checkOutput("ram_en",     bus.ram_en,     exp_en[c]);
        checkOutput("ram_we",     bus.ram_we,     exp_we[c]);
        checkOutput("ram_addr",   bus.ram_addr,   exp_addr[c]);
        checkOutput("ram_wdata",  bus.ram_wdata,  exp_wd[c]);
        checkOutput("cpu_ack",    bus.cpu_ack,    exp_ack[c]);
        checkOutput("cpu_rdata",  bus.cpu_rdata,  hold_m);
        checkOutput("byte_valid", bus.byte_valid, sv);
        checkOutput("byte_out",   bus.byte_out,   sb);
        checkOutput("byte_last",  bus.byte_last,  sl);
      end
      if (rst) begin
        armed    = 1'b1;
        idle_at  = c + 1;
        starve_m = 0;
        hold_m   = '0;
        q_m.delete();
        for (int k = 1; k <= 3; k++) begin
          exp_en[c+k] = 0; exp_we[c+k] = 0; exp_addr[c+k] = '0; exp_wd[c+k] = '0;
          exp_ack[c+k] = 0; exp_rdv[c+k] = 0; exp_rdd[c+k] = '0;
        end
      end else if (armed) begin
        if (sv && bus.byte_ready) void'(q_m.pop_front());
        if (c >= idle_at) begin
          host_ok = bus.host_req && !sv;
          if (host_ok && (starve_m == STARVE_MAX || !bus.cpu_req)) begin
            starve_m = 0;
            w = mem_m[bus.host_addr];
            q_m.delete();
            for (int k = 0; k < DATA_W / 8; k++) q_m.push_back(w[8*k +: 8]);
            sstart   = c + 3;
            idle_at  = c + 3;
            exp_en[c+1]   = 1;
            exp_addr[c+1] = bus.host_addr;
          end else if (bus.cpu_req) begin
            if (host_ok && starve_m < STARVE_MAX) starve_m++;
            exp_en[c+1]   = 1;
            exp_we[c+1]   = bus.cpu_we;
            exp_addr[c+1] = bus.cpu_addr;
            exp_wd[c+1]   = bus.cpu_wdata;
            exp_ack[c+2]  = 1;
            if (!bus.cpu_we) begin
              exp_rdv[c+2] = 1;
              exp_rdd[c+2] = mem_m[bus.cpu_addr];
            end else begin
              mem_m[bus.cpu_addr] = bus.cpu_wdata;
            end
            idle_at = c + 3;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit cr, input bit cw,
                               input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                               input bit hr, input logic [ADDR_W-1:0] ha, input bit rdy);
    @(posedge clk);
    #1;
    rst           = r;
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.host_req  = hr;
    bus.host_addr = ha;
    bus.byte_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idleCycle(input bit rdy);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, rdy);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] exp_b [4];
    logic [7:0] exp_c [4];
    logic [7:0] got [$];
    logic [7:0] prev_b;
    bit prev_stall;
    bit seen;
    int grants;
    logic [DATA_W-1:0] v;

    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_c = '{8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < WORDS; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      mem_m[i]   = v;
    end
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_req = 0; bus.host_addr = '0; bus.byte_ready = 0;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, '0, '0, 0, '0, 0);
    applyStimulus(1, 0, 0, '0, '0, 0, '0, 0);
    idleCycle(0);
    checkOutput("reset_ram_en", bus.ram_en, 0);
    checkOutput("reset_byte_valid", bus.byte_valid, 0);
    checkOutput("reset_cpu_rdata", bus.cpu_rdata, 0);

    $display("[TB] CPU write then read");
    applyStimulus(0, 1, 1, 5'd3, 32'hDEADBEEF, 0, '0, 1);
    idleCycle(1);
    checkOutput("t1_wr_en", bus.ram_en, 1);
    checkOutput("t1_wr_we", bus.ram_we, 1);
    checkOutput("t1_wr_addr", bus.ram_addr, 3);
    idleCycle(1);
    checkOutput("t1_wr_ack", bus.cpu_ack, 1);
    applyStimulus(0, 1, 0, 5'd3, '0, 0, '0, 1);
    checkOutput("t1_ack_single", bus.cpu_ack, 0);
    idleCycle(1);
    checkOutput("t1_rd_en", bus.ram_en, 1);
    checkOutput("t1_rd_we", bus.ram_we, 0);
    idleCycle(1);
    checkOutput("t1_rd_ack", bus.cpu_ack, 1);
    checkOutput("t1_rd_data", bus.cpu_rdata, 32'hDEADBEEF);
    idleCycle(1);
    checkOutput("t1_rd_hold", bus.cpu_rdata, 32'hDEADBEEF);

    $display("[TB] host read with ready high");
    applyStimulus(0, 0, 0, '0, '0, 1, 5'd3, 1);
    idleCycle(1);
    idleCycle(1);
    checkOutput("t2_not_yet_valid", bus.byte_valid, 0);
    for (int k = 0; k < 4; k++) begin
      idleCycle(1);
      checkOutput("t2_valid", bus.byte_valid, 1);
      checkOutput("t2_byte", bus.byte_out, exp_b[k]);
      checkOutput("t2_last", bus.byte_last, (k == 3));
    end
    idleCycle(1);
    checkOutput("t2_done", bus.byte_valid, 0);

    $display("[TB] host read with stalls");
    applyStimulus(0, 0, 0, '0, '0, 1, 5'd3, 0);
    got.delete();
    prev_stall = 0;
    prev_b = '0;
    for (int i = 0; i < 40; i++) begin
      idleCycle((i % 4 == 0) || (i % 4 == 3));
      if (prev_stall) checkOutput("t3_stall_stable", bus.byte_out, prev_b);
      prev_stall = bus.byte_valid && !bus.byte_ready;
      prev_b = bus.byte_out;
      if (bus.byte_valid && bus.byte_ready) begin
        got.push_back(bus.byte_out);
        if (bus.byte_last) break;
      end
    end
    checkOutput("t3_count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) checkOutput("t3_byte", got[k], exp_b[k]);
    idleCycle(1);
    idleCycle(1);

    $display("[TB] starvation guard");
    for (int round = 0; round < 2; round++) begin
      grants = 0;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
        applyStimulus(0, 1, 0, 5'd1, '0, 1, 5'd5, 1);
        if (i > 0 && bus.ram_en) begin
          if (bus.ram_addr == 5'd5) begin
            seen = 1;
            break;
          end
          grants++;
        end
      end
      checkOutput("t4_host_granted", seen, 1);
      checkOutput("t4_cpu_grants", grants, STARVE_MAX);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 5'd1, '0, 0, '0, 1);
    end
    for (int i = 0; i < 4; i++) idleCycle(1);

    $display("[TB] CPU access during stalled stream");
    applyStimulus(0, 1, 1, 5'd7, 32'h11223344, 0, '0, 0);
    for (int i = 0; i < 3; i++) idleCycle(0);
    applyStimulus(0, 0, 0, '0, '0, 1, 5'd7, 0);
    for (int i = 0; i < 10; i++) begin
      idleCycle(0);
      if (bus.byte_valid) break;
    end
    checkOutput("t5_stream_started", bus.byte_valid, 1);
    idleCycle(0);
    applyStimulus(0, 1, 1, 5'd9, 32'hCAFEF00D, 0, '0, 0);
    idleCycle(0);
    checkOutput("t5_cpu_en", bus.ram_en, 1);
    idleCycle(0);
    checkOutput("t5_cpu_ack", bus.cpu_ack, 1);
    got.delete();
    for (int i = 0; i < 20; i++) begin
      idleCycle(1);
      if (bus.byte_valid) begin
        got.push_back(bus.byte_out);
        if (bus.byte_last) break;
      end
    end
    checkOutput("t5_count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) checkOutput("t5_byte", got[k], exp_c[k]);
    idleCycle(1);

    $display("[TB] reset during access and stream");
    applyStimulus(0, 1, 1, 5'd10, 32'h55AA55AA, 0, '0, 0);
    applyStimulus(1, 0, 0, '0, '0, 0, '0, 0);
    idleCycle(0);
    checkOutput("t6_no_ack", bus.cpu_ack, 0);
    applyStimulus(0, 0, 0, '0, '0, 1, 5'd3, 0);
    for (int i = 0; i < 10; i++) begin
      idleCycle(0);
      if (bus.byte_valid) break;
    end
    checkOutput("t6_stream_started", bus.byte_valid, 1);
    applyStimulus(1, 0, 0, '0, '0, 0, '0, 0);
    idleCycle(0);
    checkOutput("t6_flushed", bus.byte_valid, 0);
    checkOutput("t6_flushed_last", bus.byte_last, 0);
    applyStimulus(0, 1, 0, 5'd3, '0, 0, '0, 1);
    idleCycle(1);
    checkOutput("t6_after_en", bus.ram_en, 1);
    idleCycle(1);
    checkOutput("t6_after_ack", bus.cpu_ack, 1);
    checkOutput("t6_after_data", bus.cpu_rdata, 32'hDEADBEEF);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2500; i++) begin
      applyStimulus($urandom_range(0, 299) == 0,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 1) == 1,
                    ADDR_W'($urandom_range(0, 7)),
                    $urandom,
                    $urandom_range(0, 1) == 1,
                    ADDR_W'($urandom_range(0, 7)),
                    $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 8; i++) idleCycle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
